// File: rtl/universal_shift_reg.sv
// Universal shift register with manual hold/shift/load modes and an automatic
// load-then-shift burst that streams the loaded word out of the MSB.
module universal_shift_reg #(
    parameter int WIDTH = 8,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             rotate,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    input  logic [WIDTH-1:0] p_in,
    input  logic             start,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic [WIDTH-1:0] status,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    shift_count
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] shl_s;
    logic [WIDTH-1:0] shr_s;
    logic [CW-1:0]    cnt_inc_s;

    // Shift candidates and saturating shift counter increment
    always_comb begin
        shl_s     = {q_q[WIDTH-2:0], rotate ? q_q[WIDTH-1] : sin_lsb};
        shr_s     = {rotate ? q_q[0] : sin_msb, q_q[WIDTH-1:1]};
        if (cnt_q == CNT_MAX) begin
            cnt_inc_s = cnt_q;
        end else begin
            cnt_inc_s = cnt_q + CW'(1);
        end
    end

    // Next-state logic: burst sequencing overrides manual mode decoding
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    q_d     = p_in;
                    cnt_d   = '0;
                    state_d = BURST;
                end else begin
                    case (mode)
                        2'b00: begin
                            q_d = q_q;
                        end
                        2'b01: begin
                            q_d   = shl_s;
                            cnt_d = cnt_inc_s;
                        end
                        2'b10: begin
                            q_d   = shr_s;
                            cnt_d = cnt_inc_s;
                        end
                        2'b11: begin
                            q_d   = p_in;
                            cnt_d = '0;
                        end
                        default: begin
                            q_d = q_q;
                        end
                    endcase
                end
            end
            BURST: begin
                q_d   = shl_s;
                cnt_d = cnt_inc_s;
                // The last shift of the burst drops back to IDLE so a held
                // start can launch the next burst on the following edge.
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = BURST;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign sout_msb    = q_q[WIDTH-1];
    assign sout_lsb    = q_q[0];
    assign status      = q_q;
    assign busy        = (state_q == BURST);
    assign done        = done_q;
    assign shift_count = cnt_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg at WIDTH=8.
module tb_universal_shift_reg;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk;
    logic             reset;
    logic [1:0]       mode;
    logic             rotate;
    logic             sin_lsb;
    logic             sin_msb;
    logic [WIDTH-1:0] p_in;
    logic             start;
    logic             sout_msb;
    logic             sout_lsb;
    logic [WIDTH-1:0] status;
    logic             busy;
    logic             done;
    logic [CW-1:0]    shift_count;

    int checks = 0;
    int errors = 0;

    universal_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .rotate      (rotate),
        .sin_lsb     (sin_lsb),
        .sin_msb     (sin_msb),
        .p_in        (p_in),
        .start       (start),
        .sout_msb    (sout_msb),
        .sout_lsb    (sout_lsb),
        .status      (status),
        .busy        (busy),
        .done        (done),
        .shift_count (shift_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_bits;
        int         done_cnt;

        reset   = 1'b1;
        mode    = 2'b00;
        rotate  = 1'b0;
        sin_lsb = 1'b0;
        sin_msb = 1'b0;
        p_in    = 8'h00;
        start   = 1'b0;
        #2;
        chk("rst_status", 32'(status), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_cnt", 32'(shift_count), 32'h0);
        step();
        step();
        reset = 1'b0;

        // Load and manual shifts
        mode = 2'b11; p_in = 8'hA5;
        step();
        chk("load_status", 32'(status), 32'hA5);
        chk("load_cnt", 32'(shift_count), 32'h0);
        chk("load_souts", 32'({sout_msb, sout_lsb}), 32'h3);
        mode = 2'b01; sin_lsb = 1'b1; rotate = 1'b0;
        step();
        chk("shl_status", 32'(status), 32'h4B);
        mode = 2'b10; sin_msb = 1'b0;
        step();
        chk("shr_status", 32'(status), 32'h25);
        chk("shr_cnt", 32'(shift_count), 32'h2);
        chk("manual_no_done", 32'(done), 32'h0);
        mode = 2'b00;
        step();
        chk("hold_status", 32'(status), 32'h25);
        chk("hold_cnt", 32'(shift_count), 32'h2);

        // Rotate right and counter saturation
        mode = 2'b11; p_in = 8'hA5;
        step();
        mode = 2'b10; rotate = 1'b1;
        step();
        chk("rotr_status", 32'(status), 32'hD2);
        chk("rotr_cnt", 32'(shift_count), 32'h1);
        for (int i = 0; i < 10; i++) step();
        chk("sat_cnt", 32'(shift_count), 32'h8);
        chk("rotr11_status", 32'(status), 32'hB4);
        chk("sat_no_done", 32'(done), 32'h0);
        mode = 2'b00; rotate = 1'b0;

        // Burst with zero fill
        start = 1'b1; p_in = 8'hC3; sin_lsb = 1'b0;
        step();
        start = 1'b0; p_in = 8'h00;
        chk("b1_load", 32'(status), 32'hC3);
        chk("b1_cnt0", 32'(shift_count), 32'h0);
        exp_bits = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            chk("b1_busy", 32'(busy), 32'h1);
            chk("b1_sout", 32'(sout_msb), 32'(exp_bits[7-i]));
            chk("b1_nodone", 32'(done), 32'h0);
            step();
        end
        chk("b1_busy_end", 32'(busy), 32'h0);
        chk("b1_done", 32'(done), 32'h1);
        chk("b1_status", 32'(status), 32'h00);
        chk("b1_cnt", 32'(shift_count), 32'h8);
        step();
        chk("b1_done_pulse", 32'(done), 32'h0);

        // Rotating burst ignores start and mode while busy
        rotate = 1'b1; start = 1'b1; p_in = 8'h81;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i == 2) begin
                start = 1'b1; mode = 2'b11; p_in = 8'h5A;
            end else begin
                start = 1'b0; mode = 2'b11; p_in = 8'h5A;
            end
            step();
        end
        start = 1'b0; mode = 2'b00;
        chk("b2_busy_last", 32'(busy), 32'h1);
        step();
        chk("b2_done", 32'(done), 32'h1);
        chk("b2_status", 32'(status), 32'h81);
        chk("b2_cnt", 32'(shift_count), 32'h8);
        step();
        chk("b2_idle", 32'(busy), 32'h0);
        rotate = 1'b0;

        // Asynchronous reset mid-burst
        start = 1'b1; p_in = 8'hFF; sin_lsb = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("b3_cnt3", 32'(shift_count), 32'h3);
        #2 reset = 1'b1;
        #1;
        chk("ar_status", 32'(status), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_cnt", 32'(shift_count), 32'h0);
        step();
        reset = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) done_cnt++;
        end
        chk("ar_no_done", 32'(done_cnt), 32'h0);
        chk("ar_idle", 32'(busy), 32'h0);

        // First edge after reset release is processed
        reset = 1'b1;
        #3 reset = 1'b0;
        mode = 2'b11; p_in = 8'h3C;
        step();
        chk("post_rst_load", 32'(status), 32'h3C);
        mode = 2'b00;

        // Back-to-back bursts with start held
        start = 1'b1; p_in = 8'hA5; sin_lsb = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 18; k++) begin
            step();
            if (done) done_cnt++;
            chk("bb_done", 32'(done), ((k == 8) || (k == 17)) ? 32'h1 : 32'h0);
            chk("bb_busy", 32'(busy), ((k == 8) || (k == 17)) ? 32'h0 : 32'h1);
            if (k == 9) begin
                chk("bb_reload", 32'(status), 32'hA5);
                chk("bb_reload_cnt", 32'(shift_count), 32'h0);
            end
        end
        start = 1'b0;
        chk("bb_done_count", 32'(done_cnt), 32'h2);
        step();
        chk("bb_idle", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
